// File: rtl/rrf_alloc_pkg.sv
// Shared constants for the rename-register free-list allocator.
//   RRF_NUM : number of rename registers (power of two)
//   RRF_SEL : tag width, log2(RRF_NUM)
//   COM_NUM : width of the per-cycle commit count
package rrf_alloc_pkg;
  localparam int RRF_NUM = 64;
  localparam int RRF_SEL = 6;
  localparam int COM_NUM = 2;
endpackage

// File: rtl/rrf_alloc.sv
// Rename-register free-list allocator.
// Hands out up to two tags per cycle in strict circular order. Tags are
// reclaimed at commit. On a mispredict the allocation pointer rolls back.
//   req1/req2, dp_stall      : dispatch requests and downstream stall
//   dpaddr1/2, dpen1/2       : granted tags and RRF valid-clear strobes
//   alloc_stall              : requests present but not granted
//   com_num                  : tags retired this cycle (0..2)
//   prmiss, rb_tag, rb_cyc   : mispredict flush and the new allocation point
//   rrfptr/rrfcyc, comptr    : allocation head (with wrap bit) and oldest tag
//   freenum                  : free tag count (0..RRF_NUM)
module rrf_alloc
  import rrf_alloc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               req1,
  input  logic               req2,
  input  logic               dp_stall,
  output logic [RRF_SEL-1:0] dpaddr1,
  output logic [RRF_SEL-1:0] dpaddr2,
  output logic               dpen1,
  output logic               dpen2,
  output logic               alloc_stall,
  input  logic [COM_NUM-1:0] com_num,
  input  logic               prmiss,
  input  logic [RRF_SEL-1:0] rb_tag,
  input  logic               rb_cyc,
  output logic [RRF_SEL-1:0] rrfptr,
  output logic               rrfcyc,
  output logic [RRF_SEL-1:0] comptr,
  output logic [RRF_SEL:0]   freenum
);

  // {cycle bit, pointer}: because RRF_NUM is a power of two, a plain add on
  // the concatenation wraps the pointer and toggles the cycle bit together.
  function automatic logic [RRF_SEL:0] adv(input logic [RRF_SEL:0] p,
                                           input logic [1:0]       n);
    return p + {{(RRF_SEL-1){1'b0}}, n};
  endfunction

  localparam logic [RRF_SEL:0] FREE_ALL = (RRF_SEL+1)'(RRF_NUM);

  logic [RRF_SEL:0] rrf_q, rrf_d;      // {rrfcyc, rrfptr}
  logic [RRF_SEL:0] com_q, com_d;      // {comcyc, comptr}
  logic [RRF_SEL:0] freenum_q, freenum_d;
  logic [1:0]       reqcnt;
  logic [RRF_SEL:0] need, com_ext, occ;
  logic             grant;

  always_comb begin
    reqcnt  = {1'b0, req1} + {1'b0, req2};
    need    = {{(RRF_SEL-1){1'b0}}, reqcnt};
    com_ext = {{(RRF_SEL-1){1'b0}}, com_num};
    // Freed tags are only seen through freenum_q, so they become usable
    // the cycle after commit.
    grant   = ~reset & (reqcnt != 2'd0) & (freenum_q >= need) & ~dp_stall & ~prmiss;
    dpen1       = grant & req1;
    dpen2       = grant & req2;
    alloc_stall = ~reset & (reqcnt != 2'd0) & ~grant & ~prmiss;
    dpaddr1     = rrf_q[RRF_SEL-1:0];
    dpaddr2     = rrf_q[RRF_SEL-1:0] + {{(RRF_SEL-1){1'b0}}, req1};

    com_d = adv(com_q, com_num);
    // Distance mod 2N: equal positions with equal cycle bits mean empty,
    // with differing cycle bits mean full.
    occ   = {rb_cyc, rb_tag} - com_d;
    if (prmiss) begin
      rrf_d     = {rb_cyc, rb_tag};
      freenum_d = FREE_ALL - occ;
    end else begin
      rrf_d     = adv(rrf_q, grant ? reqcnt : 2'd0);
      freenum_d = freenum_q - (grant ? need : '0) + com_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rrf_q     <= '0;
      com_q     <= '0;
      freenum_q <= FREE_ALL;
    end else begin
      rrf_q     <= rrf_d;
      com_q     <= com_d;
      freenum_q <= freenum_d;
    end
  end

  assign rrfptr  = rrf_q[RRF_SEL-1:0];
  assign rrfcyc  = rrf_q[RRF_SEL];
  assign comptr  = com_q[RRF_SEL-1:0];
  assign freenum = freenum_q;

  a_com_le_occ: assert property (@(posedge clk) disable iff (reset)
    (32'(com_num) <= RRF_NUM - 32'(freenum_q)));
  a_com_max: assert property (@(posedge clk) disable iff (reset)
    (com_num <= 2'd2));
  a_occ_range: assert property (@(posedge clk) disable iff (reset)
    (prmiss |-> (occ <= FREE_ALL)));

endmodule

// File: tb/tb_rrf_alloc.sv
module tb_rrf_alloc;
  logic       clk = 1'b0;
  logic       reset, req1, req2, dp_stall, prmiss, rb_cyc;
  logic [1:0] com_num;
  logic [5:0] rb_tag, dpaddr1, dpaddr2, rrfptr, comptr;
  logic       dpen1, dpen2, alloc_stall, rrfcyc;
  logic [6:0] freenum;

  rrf_alloc dut (
    .clk(clk), .reset(reset), .req1(req1), .req2(req2), .dp_stall(dp_stall),
    .dpaddr1(dpaddr1), .dpaddr2(dpaddr2), .dpen1(dpen1), .dpen2(dpen2),
    .alloc_stall(alloc_stall), .com_num(com_num), .prmiss(prmiss),
    .rb_tag(rb_tag), .rb_cyc(rb_cyc), .rrfptr(rrfptr), .rrfcyc(rrfcyc),
    .comptr(comptr), .freenum(freenum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: absolute sequence numbers of the allocation head and the
  // commit tail. Tag = n % 64, cycle bit = (n / 64) % 2, occupancy = head-tail.
  longint head = 0;
  longint tail = 0;

  // Values seen in the most recent step, for literal checks.
  logic       cap_dpen1, cap_dpen2, cap_stall;
  logic [5:0] cap_a1, cap_a2;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare everything against the model,
  // then advance the model at the posedge.
  task automatic step(input bit r1, input bit r2, input bit st, input int cn,
                      input bit pm, input longint rabs, input bit rst);
    int     rc;
    longint fr;
    bit     g;
    @(negedge clk);
    reset = rst; req1 = r1; req2 = r2; dp_stall = st;
    com_num = 2'(cn); prmiss = pm;
    rb_tag = 6'(rabs % 64); rb_cyc = 1'((rabs / 64) % 2);
    #1;
    rc = int'(r1) + int'(r2);
    fr = 64 - (head - tail);
    g  = !rst && rc != 0 && fr >= rc && !st && !pm;
    chk("rrfptr",  rrfptr,  head % 64);
    chk("rrfcyc",  rrfcyc,  (head / 64) % 2);
    chk("comptr",  comptr,  tail % 64);
    chk("freenum", freenum, fr);
    chk("dpen1",   dpen1,   g && r1);
    chk("dpen2",   dpen2,   g && r2);
    chk("alloc_stall", alloc_stall, !rst && rc != 0 && !g && !pm);
    chk("dpaddr1", dpaddr1, head % 64);
    chk("dpaddr2", dpaddr2, (head + r1) % 64);
    cap_dpen1 = dpen1; cap_dpen2 = dpen2; cap_stall = alloc_stall;
    cap_a1 = dpaddr1; cap_a2 = dpaddr2;
    @(posedge clk);
    if (rst) begin
      head = 0; tail = 0;
    end else begin
      tail = tail + cn;
      if (pm)     head = rabs;
      else if (g) head = head + rc;
    end
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    reset = 1; req1 = 0; req2 = 0; dp_stall = 0; com_num = 0;
    prmiss = 0; rb_tag = 0; rb_cyc = 0;
    do_reset();

    // Reset state and first grant
    #1;
    chk("reset_freenum", freenum, 64);
    chk("reset_rrfptr", rrfptr, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("first_dpaddr1", cap_a1, 0);
    chk("first_dpaddr2", cap_a2, 1);
    chk("first_dpen", {cap_dpen1, cap_dpen2}, 3);
    #1;
    chk("first_rrfptr", rrfptr, 2);
    chk("first_freenum", freenum, 62);

    // Fill to full, then stall
    for (int i = 0; i < 31; i++) step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("full_stall", cap_stall, 1);
    chk("full_dpen", {cap_dpen1, cap_dpen2}, 0);
    chk("full_freenum", freenum, 0);

    // Freed tags are not usable in the cycle they are freed
    step(0, 0, 0, 1, 0, 0, 0);
    #1 chk("one_free", freenum, 1);
    step(1, 1, 0, 2, 0, 0, 0);
    chk("partial_nogrant", {cap_dpen1, cap_dpen2}, 0);
    chk("partial_stall", cap_stall, 1);
    #1 chk("free_after_com", freenum, 3);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("grant_after_free", {cap_dpen1, cap_dpen2}, 3);
    #1 chk("free_after_grant", freenum, 1);

    // Wrap of the allocation pointer
    do_reset();
    step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) step(1, 1, 0, 2, 0, 0, 0);
    step(1, 0, 0, 2, 0, 0, 0);
    #1 chk("pre_wrap_ptr", rrfptr, 63);
    step(1, 1, 0, 1, 0, 0, 0);
    chk("wrap_dpaddr1", cap_a1, 63);
    chk("wrap_dpaddr2", cap_a2, 0);
    #1;
    chk("wrap_rrfptr", rrfptr, 1);
    chk("wrap_rrfcyc", rrfcyc, 1);

    // Rollback
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)  step(0, 0, 0, 2, 0, 0, 0);
    step(1, 1, 0, 2, 1, 20, 0);
    chk("rb_dpen", {cap_dpen1, cap_dpen2}, 0);
    #1;
    chk("rb_rrfptr", rrfptr, 20);
    chk("rb_comptr", comptr, 12);
    chk("rb_freenum", freenum, 56);
    step(0, 0, 0, 0, 1, 64 + 12, 0);
    #1 chk("rb_full_freenum", freenum, 0);
    step(0, 0, 0, 0, 1, 12, 0);
    #1 chk("rb_empty_freenum", freenum, 64);

    // Reset in the middle of traffic
    for (int i = 0; i < 7; i++) step(1, 1, 0, (i > 0) ? 1 : 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 1);
    chk("midrst_dpen", {cap_dpen1, cap_dpen2}, 0);
    #1;
    chk("midrst_rrfptr", rrfptr, 0);
    chk("midrst_comptr", comptr, 0);
    chk("midrst_freenum", freenum, 64);
    step(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit     r1, r2, st, pm;
      int     cn, occ;
      longint rabs;
      r1  = 1'($urandom_range(0, 1));
      r2  = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 9) == 0);
      occ = int'(head - tail);
      cn  = $urandom_range(0, (occ < 2) ? occ : 2);
      // Bias commits down in the first half so the list actually fills.
      if (i < 1500 && $urandom_range(0, 2) != 0) cn = 0;
      pm  = ($urandom_range(0, 24) == 0);
      rabs = tail + cn + $urandom_range(0, int'(head - tail) - cn);
      step(r1, r2, st, cn, pm, rabs, ($urandom_range(0, 499) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
